// File: rtl/chngy_operand_seq_if.sv
// Signal bundle between the change-in-Y sequencer, the change record source, Y storage and the datapath.
// The master side is the sequencer; the slave side is everything around it.
interface chngy_operand_seq_if #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 48
);
  logic              chg_valid;
  logic              chg_ready;
  logic [IDX_W-1:0]  chg_row;
  logic [IDX_W-1:0]  chg_col;
  logic [DATA_W-1:0] chg_dy;

  logic              ymem_rd_en;
  logic [ADDR_W-1:0] ymem_rd_addr;
  logic [DATA_W-1:0] ymem_rd_data;
  logic              ymem_wr_en;
  logic [ADDR_W-1:0] ymem_wr_addr;
  logic [DATA_W-1:0] ymem_wr_data;

  logic              dp_enable;
  logic [DATA_W-1:0] dp_y1;
  logic [DATA_W-1:0] dp_y2;
  logic [DATA_W-1:0] dp_result;
  logic              dp_exdone;
  logic              dp_done;

  modport master (
    input  chg_valid, chg_row, chg_col, chg_dy,
    output chg_ready,
    output ymem_rd_en, ymem_rd_addr,
    input  ymem_rd_data,
    output ymem_wr_en, ymem_wr_addr, ymem_wr_data,
    output dp_enable, dp_y1, dp_y2,
    input  dp_result, dp_exdone, dp_done
  );

  modport slave (
    output chg_valid, chg_row, chg_col, chg_dy,
    input  chg_ready,
    input  ymem_rd_en, ymem_rd_addr,
    output ymem_rd_data,
    input  ymem_wr_en, ymem_wr_addr, ymem_wr_data,
    input  dp_enable, dp_y1, dp_y2,
    output dp_result, dp_exdone, dp_done
  );
endinterface

// File: rtl/chngy_operand_seq.sv
// Change-in-Y sequencer: takes one (row, col, dY) record, streams the affected Y entries through the
// datapath as P/D operand beats and writes every result back to Y storage.
module chngy_operand_seq #(
  parameter int N_NODES = 16,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 48,
  parameter int CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  chngy_operand_seq_if.master  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     chg_count,
  output logic                 err_zero_op,
  output logic                 err_proto,
  output logic                 err_range
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ISSUE,
    S_WB,
    S_FLUSH
  } state_t;

  localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_NODES);

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(N_NODES) + ADDR_W'(c);
  endfunction

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  row_reg;
  logic [IDX_W-1:0]  col_reg;
  logic [DATA_W-1:0] dy_reg;
  logic [DATA_W-1:0] op_reg;
  logic [1:0]        beat_reg;
  logic [1:0]        last_reg;
  logic              clean_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              err_zero_reg;
  logic              err_proto_reg;
  logic              err_range_reg;

  logic              accept;
  logic              range_bad;
  logic              dy_zero;
  logic              zero_hit;
  logic              proto_hit;
  logic              wb_ok;
  logic              is_d;
  logic              is_last;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beat_addr [4];

  // Beat order: P(r,c), D(r,r), P(c,r), D(c,c); odd beats are the diagonal D beats.
  for (genvar gi = 0; gi < 4; gi++) begin : g_beat
    localparam bit ROW_FROM_COL = (gi >= 2);
    localparam bit COL_FROM_ROW = (gi == 1) || (gi == 2);
    assign beat_addr[gi] = addr_of(ROW_FROM_COL ? col_reg : row_reg,
                                   COL_FROM_ROW ? row_reg : col_reg);
  end

  assign cur_addr  = beat_addr[beat_reg];
  assign is_d      = beat_reg[0];
  assign is_last   = (beat_reg == last_reg);
  assign range_bad = ({1'b0, bus.chg_row} >= N_LIM) || ({1'b0, bus.chg_col} >= N_LIM);
  assign dy_zero   = (bus.chg_dy == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      dy_reg        <= '0;
      op_reg        <= '0;
      beat_reg      <= '0;
      last_reg      <= '0;
      clean_reg     <= 1'b0;
      count_reg     <= '0;
      err_zero_reg  <= 1'b0;
      err_proto_reg <= 1'b0;
      err_range_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        row_reg   <= bus.chg_row;
        col_reg   <= bus.chg_col;
        dy_reg    <= bus.chg_dy;
        beat_reg  <= 2'd0;
        last_reg  <= (bus.chg_row == bus.chg_col) ? 2'd0 : 2'd3;
        clean_reg <= 1'b1;
      end
      if (accept && range_bad) begin
        err_range_reg <= 1'b1;
      end
      if (state_reg == S_WAIT) begin
        op_reg <= bus.ymem_rd_data;
      end
      if (zero_hit) begin
        err_zero_reg <= 1'b1;
        clean_reg    <= 1'b0;
      end
      if (proto_hit) begin
        err_proto_reg <= 1'b1;
        clean_reg     <= 1'b0;
      end
      if (wb_ok && !is_last) begin
        beat_reg <= beat_reg + 2'd1;
      end
      // Aborted changes still pass through FLUSH but are not counted.
      if ((state_reg == S_FLUSH) && clean_reg) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    accept           = 1'b0;
    zero_hit         = 1'b0;
    proto_hit        = 1'b0;
    wb_ok            = 1'b0;
    bus.chg_ready    = 1'b0;
    bus.ymem_rd_en   = 1'b0;
    bus.ymem_rd_addr = '0;
    bus.ymem_wr_en   = 1'b0;
    bus.ymem_wr_addr = '0;
    bus.ymem_wr_data = '0;
    bus.dp_enable    = 1'b0;
    bus.dp_y1        = '0;
    bus.dp_y2        = '0;

    case (state_reg)
      S_IDLE: begin
        bus.chg_ready = 1'b1;
        if (bus.chg_valid) begin
          accept = 1'b1;
          // Bad indices and zero dY are consumed without touching storage.
          if (!range_bad && !dy_zero) begin
            state_next = S_READ;
          end
        end
      end
      S_READ: begin
        bus.dp_enable    = 1'b1;
        bus.ymem_rd_en   = 1'b1;
        bus.ymem_rd_addr = cur_addr;
        state_next       = S_WAIT;
      end
      S_WAIT: begin
        bus.dp_enable = 1'b1;
        if (bus.ymem_rd_data == '0) begin
          zero_hit   = 1'b1;
          state_next = S_FLUSH;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.dp_enable = 1'b1;
        bus.dp_y1     = op_reg;
        bus.dp_y2     = is_d ? '0 : dy_reg;
        state_next    = S_WB;
      end
      S_WB: begin
        bus.dp_enable = 1'b1;
        if (bus.dp_exdone && (bus.dp_done == is_d)) begin
          wb_ok            = 1'b1;
          bus.ymem_wr_en   = 1'b1;
          bus.ymem_wr_addr = cur_addr;
          bus.ymem_wr_data = bus.dp_result;
          state_next       = is_last ? S_FLUSH : S_READ;
        end else begin
          proto_hit  = 1'b1;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg != S_IDLE);
  assign chg_count   = count_reg;
  assign err_zero_op = err_zero_reg;
  assign err_proto   = err_proto_reg;
  assign err_range   = err_range_reg;

endmodule

// File: tb/tb_chngy_operand_seq.sv
// Directed bench for chngy_operand_seq with a Y storage model and a simple datapath model
// (result = y1 + y2 + 1, done when y2 == 0).
`timescale 1ns/1ps
module tb_chngy_operand_seq;
  localparam int DATA_W = 48;
  localparam int ADDR_W = 8;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              busy;
  logic [CNT_W-1:0]  chg_count;
  logic              err_zero_op;
  logic              err_proto;
  logic              err_range;

  chngy_operand_seq_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  chngy_operand_seq #(
    .N_NODES(16), .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy), .chg_count(chg_count),
    .err_zero_op(err_zero_op), .err_proto(err_proto), .err_range(err_range)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_total = 0;
  logic init_req = 1'b1;
  logic [8:0] zero_addr = 9'h100;
  int sup_beat = 0;
  logic [DATA_W-1:0] ymem [256];
  int wr_cyc_q[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return {16'h0, 8'(a), 16'h0, 8'(a) ^ 8'hA5};
  endfunction

  // Y storage: registered read, optional zero injection at one address.
  always @(posedge clock) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) ymem[i] <= init_val(i);
    end else if (bus.ymem_wr_en) begin
      ymem[bus.ymem_wr_addr] <= bus.ymem_wr_data;
    end
    if (bus.ymem_rd_en) begin
      bus.ymem_rd_data <= ({1'b0, bus.ymem_rd_addr} == zero_addr) ? '0 : ymem[bus.ymem_rd_addr];
      rd_total <= rd_total + 1;
    end
  end

  // Datapath model: result one cycle after an issued operand pair.
  logic              dp_v;
  int                dp_idx;
  logic [DATA_W-1:0] dp_a, dp_b;
  always @(posedge clock) begin
    if (reset || !bus.dp_enable) begin
      dp_v   <= 1'b0;
      dp_idx <= 0;
    end else begin
      dp_v <= (bus.dp_y1 != '0);
      if (bus.dp_y1 != '0) begin
        dp_a   <= bus.dp_y1;
        dp_b   <= bus.dp_y2;
        dp_idx <= dp_idx + 1;
      end
    end
  end
  assign bus.dp_exdone = dp_v && (dp_idx != sup_beat);
  assign bus.dp_done   = dp_v && (dp_b == '0);
  assign bus.dp_result = dp_a + dp_b + 48'd1;

  always @(posedge clock) begin
    if (bus.ymem_wr_en) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(bus.ymem_wr_addr);
      wr_data_q.push_back(bus.ymem_wr_data);
    end
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_to(input int rel);
    while (cyc < t0 + rel) tick();
  endtask

  task automatic start_change(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c, input logic [DATA_W-1:0] d);
    bus.chg_valid = 1'b1;
    bus.chg_row   = r;
    bus.chg_col   = c;
    bus.chg_dy    = d;
    t0 = cyc;
    $display("change r=%0d c=%0d dy=%h offered at cycle %0d", r, c, d, t0);
    tick();
    bus.chg_valid = 1'b0;
  endtask

  task automatic mem_reinit();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.chg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", bus.chg_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (chg_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", chg_count); end
    n_cmp++; if ({err_zero_op, err_proto, err_range} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {err_zero_op, err_proto, err_range}); end
    n_cmp++; if ({bus.dp_enable, bus.ymem_rd_en, bus.ymem_wr_en} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes got %b exp 000", {bus.dp_enable, bus.ymem_rd_en, bus.ymem_wr_en}); end
    n_cmp++; if ({bus.dp_y1, bus.dp_y2} !== 96'd0) begin n_bad++; $display("FAIL reset_operands got %h exp 0", {bus.dp_y1, bus.dp_y2}); end
  endtask

  task automatic test_offdiag();
    int base;
    int exp_c [4] = '{4, 8, 12, 16};
    logic [ADDR_W-1:0] exp_a [4] = '{8'h25, 8'h22, 8'h52, 8'h55};
    logic [DATA_W-1:0] dy = 48'h000100_000010;
    logic [DATA_W-1:0] exp_d;
    base = wr_cyc_q.size();
    start_change(5'd2, 5'd5, dy);
    run_to(3);
    n_cmp++; if (bus.dp_y1 !== init_val(8'h25) || bus.dp_y2 !== dy) begin n_bad++; $display("FAIL offdiag_p_operands got %h/%h exp %h/%h", bus.dp_y1, bus.dp_y2, init_val(8'h25), dy); end
    run_to(4);
    n_cmp++; if (bus.dp_y1 !== 48'd0) begin n_bad++; $display("FAIL offdiag_y1_idle got %h exp 0", bus.dp_y1); end
    run_to(7);
    n_cmp++; if (bus.dp_y1 !== init_val(8'h22) || bus.dp_y2 !== 48'd0) begin n_bad++; $display("FAIL offdiag_d_operands got %h/%h exp %h/0", bus.dp_y1, bus.dp_y2, init_val(8'h22)); end
    run_to(17);
    n_cmp++; if (bus.dp_enable !== 1'b0 || bus.chg_ready !== 1'b0) begin n_bad++; $display("FAIL offdiag_flush got en=%b rdy=%b exp en=0 rdy=0", bus.dp_enable, bus.chg_ready); end
    run_to(18);
    n_cmp++; if (bus.chg_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL offdiag_ready got rdy=%b busy=%b exp 1/0", bus.chg_ready, busy); end
    n_cmp++; if (chg_count !== 2'd1) begin n_bad++; $display("FAIL offdiag_count got %0d exp 1", chg_count); end
    n_cmp++; if (wr_cyc_q.size() - base !== 4) begin n_bad++; $display("FAIL offdiag_nwrites got %0d exp 4", wr_cyc_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (base + i < wr_cyc_q.size()) begin
        exp_d = init_val(exp_a[i]) + ((i % 2 == 0) ? dy : 48'd0) + 48'd1;
        n_cmp++; if (wr_cyc_q[base+i] - t0 !== exp_c[i] || wr_addr_q[base+i] !== exp_a[i] || wr_data_q[base+i] !== exp_d) begin
          n_bad++; $display("FAIL offdiag_write%0d got c=%0d a=%h d=%h exp c=%0d a=%h d=%h", i, wr_cyc_q[base+i] - t0, wr_addr_q[base+i], wr_data_q[base+i], exp_c[i], exp_a[i], exp_d);
        end
      end
    end
  endtask

  task automatic test_diag();
    int base;
    logic [DATA_W-1:0] dy = 48'h000001_000001;
    logic [DATA_W-1:0] exp_d;
    base = wr_cyc_q.size();
    exp_d = init_val(8'h33) + dy + 48'd1;
    start_change(5'd3, 5'd3, dy);
    run_to(4);
    n_cmp++; if (bus.ymem_wr_en !== 1'b1 || bus.ymem_wr_addr !== 8'h33 || bus.ymem_wr_data !== exp_d) begin n_bad++; $display("FAIL diag_write got en=%b a=%h d=%h exp 1/33/%h", bus.ymem_wr_en, bus.ymem_wr_addr, bus.ymem_wr_data, exp_d); end
    run_to(5);
    n_cmp++; if (bus.dp_enable !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL diag_flush got en=%b busy=%b exp 0/1", bus.dp_enable, busy); end
    run_to(6);
    n_cmp++; if (bus.chg_ready !== 1'b1 || chg_count !== 2'd2) begin n_bad++; $display("FAIL diag_done got rdy=%b cnt=%0d exp 1/2", bus.chg_ready, chg_count); end
    n_cmp++; if (wr_cyc_q.size() - base !== 1) begin n_bad++; $display("FAIL diag_nwrites got %0d exp 1", wr_cyc_q.size() - base); end
  endtask

  task automatic test_zero_op();
    int base;
    logic [DATA_W-1:0] dy = 48'h000100_000010;
    mem_reinit();
    zero_addr = 9'h022;
    base = wr_cyc_q.size();
    start_change(5'd2, 5'd5, dy);
    run_to(7);
    n_cmp++; if (bus.dp_enable !== 1'b0 || err_zero_op !== 1'b1) begin n_bad++; $display("FAIL zero_flush got en=%b err=%b exp 0/1", bus.dp_enable, err_zero_op); end
    run_to(8);
    n_cmp++; if (bus.chg_ready !== 1'b1 || chg_count !== 2'd2) begin n_bad++; $display("FAIL zero_done got rdy=%b cnt=%0d exp 1/2", bus.chg_ready, chg_count); end
    run_to(20);
    n_cmp++; if (wr_cyc_q.size() - base !== 1) begin n_bad++; $display("FAIL zero_nwrites got %0d exp 1", wr_cyc_q.size() - base); end
    else begin
      n_cmp++; if (wr_addr_q[base] !== 8'h25 || wr_cyc_q[base] - t0 !== 4 || wr_data_q[base] !== init_val(8'h25) + dy + 48'd1) begin n_bad++; $display("FAIL zero_write got a=%h c=%0d d=%h exp 25/4", wr_addr_q[base], wr_cyc_q[base] - t0, wr_data_q[base]); end
    end
    zero_addr = 9'h100;
  endtask

  task automatic test_proto();
    int base;
    mem_reinit();
    sup_beat = 2;
    base = wr_cyc_q.size();
    start_change(5'd2, 5'd5, 48'h000100_000010);
    run_to(8);
    n_cmp++; if (bus.ymem_wr_en !== 1'b0) begin n_bad++; $display("FAIL proto_nowrite got %b exp 0", bus.ymem_wr_en); end
    run_to(9);
    n_cmp++; if (bus.dp_enable !== 1'b0 || busy !== 1'b1 || err_proto !== 1'b1) begin n_bad++; $display("FAIL proto_flush got en=%b busy=%b err=%b exp 0/1/1", bus.dp_enable, busy, err_proto); end
    run_to(10);
    n_cmp++; if (bus.chg_ready !== 1'b1 || chg_count !== 2'd2) begin n_bad++; $display("FAIL proto_done got rdy=%b cnt=%0d exp 1/2", bus.chg_ready, chg_count); end
    run_to(20);
    n_cmp++; if (wr_cyc_q.size() - base !== 1) begin n_bad++; $display("FAIL proto_nwrites got %0d exp 1", wr_cyc_q.size() - base); end
    sup_beat = 0;
  endtask

  task automatic test_range_and_zero_dy();
    int base, rd0;
    base = wr_cyc_q.size();
    rd0 = rd_total;
    n_cmp++; if (err_range !== 1'b0) begin n_bad++; $display("FAIL range_before got %b exp 0", err_range); end
    start_change(5'd16, 5'd3, 48'h000001_000000);
    n_cmp++; if (err_range !== 1'b1 || busy !== 1'b0 || bus.chg_ready !== 1'b1) begin n_bad++; $display("FAIL range_flag got err=%b busy=%b rdy=%b exp 1/0/1", err_range, busy, bus.chg_ready); end
    start_change(5'd1, 5'd1, 48'd0);
    n_cmp++; if (busy !== 1'b0 || bus.chg_ready !== 1'b1) begin n_bad++; $display("FAIL zerody_idle got busy=%b rdy=%b exp 0/1", busy, bus.chg_ready); end
    run_to(6);
    n_cmp++; if (rd_total !== rd0 || wr_cyc_q.size() !== base || chg_count !== 2'd2) begin n_bad++; $display("FAIL noaccess got rd=%0d wr=%0d cnt=%0d exp 0/0/2", rd_total - rd0, wr_cyc_q.size() - base, chg_count); end
  endtask

  task automatic test_reset_mid();
    int base, rd0;
    base = wr_cyc_q.size();
    start_change(5'd2, 5'd5, 48'h000100_000010);
    run_to(10);
    reset = 1'b1;
    run_to(11);
    n_cmp++; if (bus.chg_ready !== 1'b1 || busy !== 1'b0 || bus.dp_enable !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle got rdy=%b busy=%b en=%b exp 1/0/0", bus.chg_ready, busy, bus.dp_enable); end
    n_cmp++; if ({err_zero_op, err_proto, err_range} !== 3'b000 || chg_count !== 2'd0) begin n_bad++; $display("FAIL rstmid_state got flags=%b cnt=%0d exp 000/0", {err_zero_op, err_proto, err_range}, chg_count); end
    reset = 1'b0;
    rd0 = rd_total;
    run_to(30);
    n_cmp++; if (wr_cyc_q.size() - base !== 2 || rd_total !== rd0) begin n_bad++; $display("FAIL rstmid_access got wr=%0d rd=%0d exp 2/0", wr_cyc_q.size() - base, rd_total - rd0); end
  endtask

  task automatic test_count_wrap();
    logic [CNT_W-1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      start_change(5'(i + 1), 5'(i + 1), 48'h000002_000003);
      run_to(6);
      n_cmp++; if (chg_count !== exp_cnt[i]) begin n_bad++; $display("FAIL wrap_count%0d got %0d exp %0d", i, chg_count, exp_cnt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [DATA_W-1:0] dy = 48'h000010_000020;
    base = wr_cyc_q.size();
    bus.chg_valid = 1'b1;
    bus.chg_row = 5'd7; bus.chg_col = 5'd7; bus.chg_dy = dy;
    t0 = cyc;
    $display("change r=7 c=7 dy=%h offered at cycle %0d, r=8 c=8 held behind it", dy, t0);
    tick();
    bus.chg_row = 5'd8; bus.chg_col = 5'd8;
    run_to(3);
    n_cmp++; if (bus.chg_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_busy got %b exp 0", bus.chg_ready); end
    run_to(6);
    n_cmp++; if (bus.chg_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_again got %b exp 1", bus.chg_ready); end
    tick();
    bus.chg_valid = 1'b0;
    run_to(13);
    n_cmp++; if (wr_cyc_q.size() - base !== 2) begin n_bad++; $display("FAIL b2b_nwrites got %0d exp 2", wr_cyc_q.size() - base); end
    else begin
      n_cmp++; if (wr_cyc_q[base] - t0 !== 4 || wr_addr_q[base] !== 8'h77 || wr_data_q[base] !== init_val(8'h77) + dy + 48'd1) begin n_bad++; $display("FAIL b2b_write0 got c=%0d a=%h d=%h exp 4/77", wr_cyc_q[base] - t0, wr_addr_q[base], wr_data_q[base]); end
      n_cmp++; if (wr_cyc_q[base+1] - t0 !== 10 || wr_addr_q[base+1] !== 8'h88 || wr_data_q[base+1] !== init_val(8'h88) + dy + 48'd1) begin n_bad++; $display("FAIL b2b_write1 got c=%0d a=%h d=%h exp 10/88", wr_cyc_q[base+1] - t0, wr_addr_q[base+1], wr_data_q[base+1]); end
    end
    n_cmp++; if (chg_count !== 2'd2) begin n_bad++; $display("FAIL b2b_count got %0d exp 2", chg_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.chg_valid = 1'b0;
    bus.chg_row   = '0;
    bus.chg_col   = '0;
    bus.chg_dy    = '0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b0;
    init_req = 1'b0;
    test_reset();
    test_offdiag();
    test_diag();
    test_zero_op();
    test_proto();
    test_range_and_zero_dy();
    test_reset_mid();
    test_count_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
